// File: rtl/pc_pkg.sv
// Shared definitions for the PC unit and the control unit: datapath width,
// reset vector, sequential increment and the next-PC select encoding.
package pc_pkg;

  localparam int unsigned XLEN        = 64;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int unsigned INSTR_BYTES = 4;

  // Next-PC select, driven by the control unit on soma_imm
  typedef enum logic {
    PC_SEL_SEQ = 1'b0,
    PC_SEL_IMM = 1'b1
  } pc_sel_e;

endpackage : pc_pkg

// File: rtl/pc_next_adder.sv
// Combinational next-PC adder: sequential advance and immediate-relative
// target, selected by soma_imm. Arithmetic wraps modulo 2^XLEN.
module pc_next_adder #(
  parameter int unsigned XLEN        = pc_pkg::XLEN,
  parameter int unsigned INSTR_BYTES = pc_pkg::INSTR_BYTES
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            soma_imm,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_plus4
);

  import pc_pkg::*;

  pc_sel_e sel;

  assign sel = pc_sel_e'(soma_imm);

  // Both candidates are computed every cycle; imm is a raw byte offset
  always_comb begin
    pc_plus4 = pc + XLEN'(INSTR_BYTES);
    pc_next  = pc_plus4;
    if (sel == PC_SEL_IMM) begin
      pc_next = pc + imm;
    end
  end

endmodule : pc_next_adder

// File: rtl/pc_unit.sv
// Program counter register with next-PC computation for the multicycle core.
// Optional feature: define PC_ALIGN_CHECK_EN to flag and suppress updates to
// next-PC values that are not 4-byte aligned.
module pc_unit #(
  parameter int unsigned      XLEN        = pc_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(pc_pkg::RESET_PC),
  parameter int unsigned      INSTR_BYTES = pc_pkg::INSTR_BYTES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_en,
  input  logic            soma_imm,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  logic pc_load;

  pc_next_adder #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_adder (
    .pc       (pc),
    .imm      (imm),
    .soma_imm (soma_imm),
    .pc_next  (pc_next),
    .pc_plus4 (pc_plus4)
  );

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = |pc_next[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // A faulting target leaves the PC on the offending instruction
  assign pc_load = pc_en & ~misaligned;

  // PC register: async reset to the reset vector, synchronous enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pc_load) begin
      pc <= pc_next;
    end
  end

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit with a queue-based scoreboard of expected PC.
module tb_pc_unit;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            clk_run;
  logic            rst_n;
  logic            pc_en;
  logic            soma_imm;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned;

  int unsigned n_tests;
  int unsigned n_fail;

  logic [XLEN-1:0] m_pc;
  logic [XLEN-1:0] exp_q[$];

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  pc_unit #(
    .XLEN        (XLEN),
    .RESET_PC    (64'h0),
    .INSTR_BYTES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_en      (pc_en),
    .soma_imm   (soma_imm),
    .imm        (imm),
    .pc         (pc),
    .pc_next    (pc_next),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, push the
  // expected post-edge PC, then pop and compare after the rising edge.
  task automatic step(input logic en, input logic sel, input logic [XLEN-1:0] im);
    logic [XLEN-1:0] e_plus4;
    logic [XLEN-1:0] e_next;
    logic            e_mis;
    logic [XLEN-1:0] e_pc;
    @(negedge clk);
    pc_en    = en;
    soma_imm = sel;
    imm      = im;
    #1;
    e_plus4 = m_pc + 64'd4;
    e_next  = sel ? m_pc + im : e_plus4;
    e_mis   = ALIGN_CHK && (e_next[1:0] != 2'b00);
    check("pc_plus4", pc_plus4, e_plus4);
    check("pc_next", pc_next, e_next);
    check("misaligned", {63'b0, misaligned}, {63'b0, e_mis});
    if (en && !e_mis) m_pc = e_next;
    exp_q.push_back(m_pc);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e_pc = exp_q.pop_front();
      check("pc", pc, e_pc);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    clk_run  = 1'b0;
    rst_n    = 1'b1;
    pc_en    = 1'b0;
    soma_imm = 1'b0;
    imm      = '0;
    m_pc     = '0;

    // Reset with no clock running
    #1 rst_n = 1'b0;
    #20;
    check("rst_static_pc", pc, 64'h0);
    check("rst_static_plus4", pc_plus4, 64'h4);
    check("rst_static_next", pc_next, 64'h4);
    clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential advance, one pulse every 4 cycles
    for (int unsigned p = 0; p < 3; p++) begin
      step(1'b1, 1'b0, 64'h0);
      for (int unsigned h = 0; h < 3; h++) step(1'b0, 1'b0, {$urandom, $urandom});
    end
    check("seq_final", pc, 64'd12);

    // Reset mid-run with enable high
    @(negedge clk);
    pc_en = 1'b1;
    soma_imm = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pc", pc, 64'h0);
    check("rst_async_plus4", pc_plus4, 64'h4);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_pc", pc, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pc_en = 1'b0;
    m_pc  = '0;

    // Relative jumps
    step(1'b1, 1'b1, 64'h100);
    step(1'b1, 1'b1, 64'h40);
    check("jump_fwd", pc, 64'h140);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    check("jump_back", pc, 64'h130);

    // Wrap-around
    step(1'b1, 1'b1, 64'h0 - 64'h134);
    check("wrap_setup", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b0, 64'h0);
    check("wrap_seq", pc, 64'h0);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b1, 64'h8);
    check("wrap_imm", pc, 64'h4);

    // Alignment
    step(1'b1, 1'b1, 64'hC);
    check("align_setup", pc, 64'h10);
    step(1'b1, 1'b1, 64'h2);
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc", pc, 64'h10);
`else
    check("align_pc", pc, 64'h12);
`endif

    // Hold with toggling inputs
    for (int unsigned h = 0; h < 10; h++) begin
      step(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_pc_unit
